// File: rtl/nand_phy_wr_burst_ctrl.sv
// rtl/nand_phy_wr_burst_ctrl.sv - NAND NV-DDR data-input burst sequencer (DQ/DQS write path)
// Optional: NAND_WR_UNDERRUN_CNT_EN adds the underrun_cnt output.
module nand_phy_wr_burst_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 16,
    parameter int PREAMBLE_CYC  = 2,
    parameter int POSTAMBLE_CYC = 1
) (
    input  logic                    clk0,
    input  logic                    rst0_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic                    abort,
    input  logic [2*DATA_WIDTH-1:0] wr_word,
    input  logic                    wr_word_valid,
    output logic                    wr_word_ready,
    output logic [DATA_WIDTH-1:0]   wr_data_rise,
    output logic [DATA_WIDTH-1:0]   wr_data_fall,
    output logic                    dq_oe_n,
    output logic                    dqs_oe_n,
    output logic                    dqs_toggle_en,
    output logic                    busy,
`ifdef NAND_WR_UNDERRUN_CNT_EN
    output logic [15:0]             underrun_cnt,
`endif
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_POST = 2'd3
    } state_t;

    localparam logic [15:0] PRE_LOAD  = 16'(PREAMBLE_CYC - 1);
    // One extra POST cycle carries the final word's DQS pulse before the quiet postamble.
    localparam logic [15:0] POST_LOAD = 16'(POSTAMBLE_CYC);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [15:0]             r_phase_cnt;
    logic [LEN_WIDTH-1:0]    r_remain;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_rise;
    logic [DATA_WIDTH-1:0]   r_fall;
    logic                    r_dq_oe_n;
    logic                    r_dqs_oe_n;
    logic                    r_toggle;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_start_go;
    logic                    w_start_zero;
    logic                    w_last_accept;
    logic                    w_post_end;

    assign w_accept      = (r_state == S_DATA) && r_ready && wr_word_valid && !abort;
    assign w_start_go    = (r_state == S_IDLE) && start && (burst_len != '0);
    assign w_start_zero  = (r_state == S_IDLE) && start && (burst_len == '0);
    assign w_last_accept = w_accept && (r_remain == LEN_WIDTH'(1));
    assign w_post_end    = (r_state == S_POST) && !abort && (r_phase_cnt == 16'd0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_go) begin
                    w_next_state = S_PRE;
                end
            end
            S_PRE: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (r_phase_cnt == 16'd0) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_last_accept) begin
                    w_next_state = S_POST;
                end
            end
            S_POST: begin
                if (abort || (r_phase_cnt == 16'd0)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            r_state     <= S_IDLE;
            r_phase_cnt <= 16'd0;
            r_remain    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE) begin
                r_phase_cnt <= PRE_LOAD;
                r_remain    <= burst_len;
            end else begin
                if ((r_state == S_DATA) && (w_next_state == S_POST)) begin
                    r_phase_cnt <= POST_LOAD;
                end else if (r_phase_cnt != 16'd0) begin
                    r_phase_cnt <= r_phase_cnt - 16'd1;
                end
                if (w_accept) begin
                    r_remain <= r_remain - LEN_WIDTH'(1);
                end
            end
        end
    end

    // Enables, ready and busy are registered from the next state so they line up with the state.
    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            r_ready    <= 1'b0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_dq_oe_n  <= 1'b1;
            r_dqs_oe_n <= 1'b1;
            r_toggle   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ready    <= (w_next_state == S_DATA);
            r_dq_oe_n  <= (w_next_state == S_IDLE);
            r_dqs_oe_n <= (w_next_state == S_IDLE);
            r_busy     <= (w_next_state != S_IDLE);
            r_toggle   <= w_accept;
            r_done     <= w_start_zero || w_post_end;
            if (w_start_go) begin
                r_rise <= '0;
                r_fall <= '0;
            end else if (w_accept) begin
                r_rise <= wr_word[DATA_WIDTH-1:0];
                r_fall <= wr_word[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

`ifdef NAND_WR_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            r_underrun_cnt <= 16'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_underrun_cnt <= 16'd0;
        end else if ((r_state == S_DATA) && !wr_word_valid && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    assign wr_word_ready = r_ready;
    assign wr_data_rise  = r_rise;
    assign wr_data_fall  = r_fall;
    assign dq_oe_n       = r_dq_oe_n;
    assign dqs_oe_n      = r_dqs_oe_n;
    assign dqs_toggle_en = r_toggle;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_nand_phy_wr_burst_ctrl.sv
// tb/tb_nand_phy_wr_burst_ctrl.sv - scoreboard bench for nand_phy_wr_burst_ctrl
module tb_nand_phy_wr_burst_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0_n;
    logic        start;
    logic [15:0] burst_len;
    logic        abort;
    logic [15:0] wr_word;
    logic        wr_word_valid;
    logic        wr_word_ready;
    logic [7:0]  wr_data_rise;
    logic [7:0]  wr_data_fall;
    logic        dq_oe_n;
    logic        dqs_oe_n;
    logic        dqs_toggle_en;
    logic        busy;
    logic        done;
`ifdef NAND_WR_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    always #5 clk0 = ~clk0;

    nand_phy_wr_burst_ctrl dut (
        .clk0          (clk0),
        .rst0_n        (rst0_n),
        .start         (start),
        .burst_len     (burst_len),
        .abort         (abort),
        .wr_word       (wr_word),
        .wr_word_valid (wr_word_valid),
        .wr_word_ready (wr_word_ready),
        .wr_data_rise  (wr_data_rise),
        .wr_data_fall  (wr_data_fall),
        .dq_oe_n       (dq_oe_n),
        .dqs_oe_n      (dqs_oe_n),
        .dqs_toggle_en (dqs_toggle_en),
        .busy          (busy),
`ifdef NAND_WR_UNDERRUN_CNT_EN
        .underrun_cnt  (underrun_cnt),
`endif
        .done          (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Every DQS pulse must carry the next expected word, in order.
    always @(negedge clk0) begin
        if (rst0_n === 1'b1 && dqs_toggle_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {16'd0, wr_data_fall, wr_data_rise}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] w;
                w = exp_q.pop_front();
                chk("word_rise", {24'd0, wr_data_rise}, {24'd0, w[7:0]});
                chk("word_fall", {24'd0, wr_data_fall}, {24'd0, w[15:8]});
                chk("word_oe", {30'd0, dq_oe_n, dqs_oe_n}, 32'd0);
            end
        end
    end

    // Called just after a negedge; drives inputs on negedges, samples outputs on negedges.
    task automatic run_burst(input string nm, input int len, input logic [15:0] base,
                             input logic [31:0] vmask, input bit hold, input int abort_at,
                             input int e_pre, input int e_rdy, input int e_post, input int e_done,
                             input logic [31:0] e_pat, input int e_plen);
        int n_pre = 0, n_rdy = 0, n_post = 0, n_done = 0, plen = 0;
        int dcyc = 0, idx = 0, tail = -1, cyc = 0, n_push;
        bit seen_busy = 0, seen_rdy = 0, rec = 0;
        logic [31:0] pat = 32'd0;
        n_push = (abort_at >= 0 && abort_at < len) ? abort_at : len;
        for (int i = 0; i < n_push; i++) exp_q.push_back(base + 16'(i));
        start     = 1'b1;
        burst_len = 16'(len);
        while (tail != 0 && cyc < 80) begin
            @(negedge clk0);
            cyc++;
            if (tail > 0) tail--;
            if (done) n_done++;
            if (busy) begin
                seen_busy = 1;
                if (wr_word_ready) begin
                    seen_rdy = 1;
                    n_rdy++;
                end else if (!dqs_toggle_en && !dq_oe_n && !dqs_oe_n) begin
                    if (!seen_rdy) n_pre++;
                    else n_post++;
                end
                if (dqs_toggle_en) rec = 1;
                if (rec) begin
                    pat = {pat[30:0], dqs_toggle_en};
                    plen++;
                end
            end else if (seen_busy && tail < 0) begin
                chk({nm, "_end_oe"}, {30'd0, dq_oe_n, dqs_oe_n}, 32'd3);
                chk({nm, "_end_rdy_tog"}, {30'd0, wr_word_ready, dqs_toggle_en}, 32'd0);
                chk({nm, "_end_done"}, {31'd0, done}, (abort_at < 0) ? 32'd1 : 32'd0);
                tail = 3;
            end
            abort         = 1'b0;
            start         = hold && busy;
            burst_len     = hold ? 16'd9 : 16'(len);
            wr_word_valid = 1'b0;
            if (wr_word_ready) begin
                wr_word = base + 16'(idx);
                if (abort_at == dcyc) begin
                    abort         = 1'b1;
                    wr_word_valid = 1'b1;
                end else begin
                    wr_word_valid = vmask[dcyc];
                    if (vmask[dcyc]) idx++;
                end
                dcyc++;
            end
        end
        start = 1'b0;
        if (tail != 0) chk({nm, "_timeout"}, 32'd1, 32'd0);
        chk({nm, "_pre_cycles"}, n_pre, e_pre);
        chk({nm, "_ready_cycles"}, n_rdy, e_rdy);
        chk({nm, "_post_cycles"}, n_post, e_post);
        chk({nm, "_done_pulses"}, n_done, e_done);
        chk({nm, "_toggle_len"}, plen, e_plen);
        chk({nm, "_toggle_pat"}, pat, e_pat);
        chk({nm, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst0_n        = 1'b0;
        start         = 1'b1;
        burst_len     = 16'd4;
        abort         = 1'b0;
        wr_word       = 16'd0;
        wr_word_valid = 1'b0;
        repeat (3) @(negedge clk0);
        chk("rst_oe", {30'd0, dq_oe_n, dqs_oe_n}, 32'd3);
        chk("rst_ctl", {28'd0, wr_word_ready, dqs_toggle_en, busy, done}, 32'd0);
        chk("rst_data", {16'd0, wr_data_fall, wr_data_rise}, 32'd0);
`ifdef NAND_WR_UNDERRUN_CNT_EN
        chk("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
`endif
        start  = 1'b0;
        rst0_n = 1'b1;
        @(negedge clk0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_burst("full4", 4, 16'hA155, 32'hFFFF_FFFF, 1'b0, -1, 2, 4, 1, 1, 32'h1E, 5);
        run_burst("stall3", 3, 16'hB210, 32'h0000_0019, 1'b0, -1, 2, 5, 1, 1, 32'h26, 6);
        run_burst("abort8", 8, 16'hC300, 32'hFFFF_FFFF, 1'b0, 2, 2, 3, 0, 0, 32'h3, 2);

        start     = 1'b1;
        burst_len = 16'd0;
        @(negedge clk0);
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_oe", {30'd0, dq_oe_n, dqs_oe_n}, 32'd3);
        @(negedge clk0);
        chk("zero_done_clear", {31'd0, done}, 32'd0);
        chk("zero_oe_hold", {30'd0, dq_oe_n, dqs_oe_n}, 32'd3);

        run_burst("hold_start", 2, 16'hD400, 32'hFFFF_FFFF, 1'b1, -1, 2, 2, 1, 1, 32'h6, 3);
        run_burst("stall5", 3, 16'hE5F0, 32'h0000_0091, 1'b0, -1, 2, 8, 1, 1, 32'h112, 9);
`ifdef NAND_WR_UNDERRUN_CNT_EN
        chk("underrun_cnt", {16'd0, underrun_cnt}, 32'd5);
        start     = 1'b1;
        burst_len = 16'd0;
        @(negedge clk0);
        start = 1'b0;
        chk("underrun_clear", {16'd0, underrun_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
